// File: rtl/sys_insn_sequencer.sv
// sys_insn_sequencer
// Multi-cycle sequencer for FENCE.I, WFI and the halt pattern. Sits beside
// decode/execute, accepts a flagged instruction, holds the pipeline, drives
// the cache maintenance handshakes and retires the instruction.
//
// Parameters
//   WFI_TIMEOUT  WFI wake-up after this many sleep cycles (0 = interrupt only)
//   CNT_W        width of the saturating WFI sleep counter
//
// Ports
//   CLK, nRST            clock, synchronous active-low reset
//   insn_valid           instruction in decode/execute is valid
//   ifence, wfi, halt    decoder flags (priority halt > ifence > wfi)
//   kill                 pipeline flush killing the current instruction
//   interrupt_pending    any enabled interrupt pending
//   dcache_flush_done    D-cache write-back complete
//   icache_clear_done    I-cache invalidate complete
//   stall                hold fetch and decode/execute (combinational)
//   dcache_flush         D-cache write-back request (level)
//   icache_clear         I-cache invalidate request (level)
//   pipe_flush           one-cycle refetch request after FENCE.I
//   seq_done             one-cycle retire pulse
//   wfi_wake             one-cycle pulse when WFI ends
//   wfi_timeout          one-cycle pulse when the sleep counter caused the wake
//   halted               sticky halt indicator
module sys_insn_sequencer #(
  parameter int unsigned WFI_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic CLK,
  input  logic nRST,
  input  logic insn_valid,
  input  logic ifence,
  input  logic wfi,
  input  logic halt,
  input  logic kill,
  input  logic interrupt_pending,
  input  logic dcache_flush_done,
  input  logic icache_clear_done,
  output logic stall,
  output logic dcache_flush,
  output logic icache_clear,
  output logic pipe_flush,
  output logic seq_done,
  output logic wfi_wake,
  output logic wfi_timeout,
  output logic halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DFLUSH,
    S_ICLEAR,
    S_WFI_WAIT,
    S_RELEASE,
    S_HALTED
  } state_e;

  // Last counter value of the sleep window; only meaningful when the
  // timeout is enabled.
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((WFI_TIMEOUT == 0) ? 0 : (WFI_TIMEOUT - 1));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fence_flag_q, fence_flag_d;
  logic             kill_flag_q, kill_flag_d;

  logic             dflush_q, dflush_d;
  logic             iclear_q, iclear_d;
  logic             pflush_q, pflush_d;
  logic             sdone_q, sdone_d;
  logic             wake_q, wake_d;
  logic             tmo_q, tmo_d;
  logic             halted_q, halted_d;

  logic             trig;
  logic             tmo_hit;
  logic             wake_hit;

  assign trig     = insn_valid & ~kill & (halt | ifence | wfi);
  assign tmo_hit  = (WFI_TIMEOUT != 0) && (cnt_q == TMO_LAST);
  assign wake_hit = interrupt_pending | tmo_hit;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fence_flag_d = fence_flag_q;
    kill_flag_d  = kill_flag_q;
    wake_d       = 1'b0;
    tmo_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        fence_flag_d = 1'b0;
        kill_flag_d  = 1'b0;
        if (trig) begin
          if (halt) begin
            state_d = S_HALTED;
          end else if (ifence) begin
            state_d = S_DFLUSH;
          end else begin
            state_d = S_WFI_WAIT;
            cnt_d   = '0;
          end
        end
      end

      // A kill during the cache handshake cannot abort it; it only
      // suppresses the retire and refetch at the end of the sequence.
      S_DFLUSH: begin
        kill_flag_d = kill_flag_q | kill;
        if (dcache_flush_done) begin
          state_d = S_ICLEAR;
        end
      end

      S_ICLEAR: begin
        kill_flag_d = kill_flag_q | kill;
        if (icache_clear_done) begin
          state_d      = S_RELEASE;
          fence_flag_d = 1'b1;
        end
      end

      S_WFI_WAIT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : (cnt_q + CNT_W'(1));
        if (kill) begin
          state_d = S_IDLE;
        end else if (wake_hit) begin
          state_d = S_RELEASE;
          wake_d  = 1'b1;
          tmo_d   = tmo_hit;
        end
      end

      // Single cycle; ignores triggers so the instruction still sitting in
      // decode is not sequenced a second time.
      S_RELEASE: begin
        state_d      = S_IDLE;
        fence_flag_d = 1'b0;
        kill_flag_d  = 1'b0;
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are derived from the next state so they line up
  // with the state they describe.
  always_comb begin
    dflush_d = (state_d == S_DFLUSH);
    iclear_d = (state_d == S_ICLEAR);
    sdone_d  = (state_d == S_RELEASE) & ~kill_flag_d;
    pflush_d = (state_d == S_RELEASE) & fence_flag_d & ~kill_flag_d;
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fence_flag_q <= 1'b0;
      kill_flag_q  <= 1'b0;
      dflush_q     <= 1'b0;
      iclear_q     <= 1'b0;
      pflush_q     <= 1'b0;
      sdone_q      <= 1'b0;
      wake_q       <= 1'b0;
      tmo_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fence_flag_q <= fence_flag_d;
      kill_flag_q  <= kill_flag_d;
      dflush_q     <= dflush_d;
      iclear_q     <= iclear_d;
      pflush_q     <= pflush_d;
      sdone_q      <= sdone_d;
      wake_q       <= wake_d;
      tmo_q        <= tmo_d;
      halted_q     <= halted_d;
    end
  end

  // Stall must cover the trigger cycle itself, hence combinational.
  always_comb begin
    case (state_q)
      S_IDLE:     stall = trig;
      S_DFLUSH,
      S_ICLEAR,
      S_WFI_WAIT,
      S_HALTED:   stall = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  assign dcache_flush = dflush_q;
  assign icache_clear = iclear_q;
  assign pipe_flush   = pflush_q;
  assign seq_done     = sdone_q;
  assign wfi_wake     = wake_q;
  assign wfi_timeout  = tmo_q;
  assign halted       = halted_q;

endmodule
